// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared defaults, data types and fetch states for the sprite row fetcher
package sprite_pkg;

    localparam int SPR_W_DEF  = 70;
    localparam int SPR_H_DEF  = 70;
    localparam int ADDR_W_DEF = 13;
    localparam int PIX_W_DEF  = 5;

    typedef logic [PIX_W_DEF-1:0]  pix_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FETCH,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/sprite_line_buf.sv
// rtl/sprite_line_buf.sv - one sprite row of palette indices, sync write / async read
module sprite_line_buf
    import sprite_pkg::*;
#(
    parameter int DEPTH = SPR_W_DEF,
    parameter int WIDTH = PIX_W_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are deliberately not reset; the fetcher's row_valid gates every read.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_row_fetcher.sv
// rtl/sprite_row_fetcher.sv - fetches the sprite row for the next line into a buffer and serves pixels by DrawX
// Optional feature: SPRITE_HFLIP_EN adds the flip_h input for horizontal mirroring.
module sprite_row_fetcher
    import sprite_pkg::*;
#(
    parameter int               SPR_W      = SPR_W_DEF,
    parameter int               SPR_H      = SPR_H_DEF,
    parameter int               ADDR_W     = ADDR_W_DEF,
    parameter int               PIX_W      = PIX_W_DEF,
    parameter logic [PIX_W-1:0] TRANSP_IDX = '0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              line_start,
    input  logic [9:0]        line_y,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic [9:0]        DrawX,
`ifdef SPRITE_HFLIP_EN
    input  logic              flip_h,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              busy,
    output logic [PIX_W-1:0]  pixel_idx,
    output logic              pixel_on
);

    localparam int                CW       = $clog2(SPR_W);
    localparam logic [CW-1:0]     COL_LAST = CW'(SPR_W - 1);
    localparam logic [9:0]        SPR_W_C  = 10'(SPR_W);
    localparam logic [9:0]        SPR_H_C  = 10'(SPR_H);
    localparam logic [ADDR_W-1:0] SPR_W_A  = ADDR_W'(SPR_W);

    fetch_state_t      state;
    logic [9:0]        line_y_r;
    logic [ADDR_W-1:0] base_r;
    logic [CW-1:0]     col;
    logic              row_valid;

    logic [10:0]       row_c;
    logic              row_hit;
    logic [ADDR_W-1:0] base_c;
    logic [CW-1:0]     col_next;

    // One extra bit so lines above the sprite show up as negative rows.
    assign row_c    = {1'b0, line_y_r} - {1'b0, sprite_y};
    assign row_hit  = !row_c[10] && (row_c[9:0] < SPR_H_C);
    assign base_c   = ADDR_W'(row_c[9:0]) * SPR_W_A;
    assign col_next = col + CW'(1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            line_y_r  <= '0;
            base_r    <= '0;
            col       <= '0;
            rom_addr  <= '0;
            busy      <= 1'b0;
            row_valid <= 1'b0;
        end else if (line_start) begin
            // A new line always wins, even mid-fetch; the old row is abandoned.
            state    <= CHECK;
            line_y_r <= line_y;
            busy     <= 1'b1;
            if (state != IDLE) begin
                row_valid <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                end
                CHECK: begin
                    row_valid <= 1'b0;
                    if (row_hit) begin
                        base_r   <= base_c;
                        rom_addr <= base_c;
                        col      <= '0;
                        state    <= FETCH;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                FETCH: begin
                    if (col == COL_LAST) begin
                        state <= DRAIN;
                    end else begin
                        col      <= col_next;
                        rom_addr <= base_r + ADDR_W'(col_next);
                    end
                end
                DRAIN: begin
                    row_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // ROM data trails its address by one cycle, so each write lands one column behind.
    logic          buf_we;
    logic [CW-1:0] buf_waddr;
    logic [CW-1:0] buf_raddr;
    logic [PIX_W-1:0] buf_rdata;

    assign buf_we    = ((state == FETCH) && (col != '0)) || (state == DRAIN);
    assign buf_waddr = (state == DRAIN) ? COL_LAST : (col - CW'(1));

    logic [10:0] dx_c;
    logic        dx_hit;

    assign dx_c   = {1'b0, DrawX} - {1'b0, sprite_x};
    assign dx_hit = !dx_c[10] && (dx_c[9:0] < SPR_W_C);

`ifdef SPRITE_HFLIP_EN
    logic flip_r;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flip_r <= 1'b0;
        end else if ((state == CHECK) && !line_start) begin
            flip_r <= flip_h;
        end
    end

    assign buf_raddr = flip_r ? (COL_LAST - dx_c[CW-1:0]) : dx_c[CW-1:0];
`else
    assign buf_raddr = dx_c[CW-1:0];
`endif

    sprite_line_buf #(
        .DEPTH (SPR_W),
        .WIDTH (PIX_W),
        .AW    (CW)
    ) u_line_buf (
        .clk   (Clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (rom_data),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_idx <= '0;
            pixel_on  <= 1'b0;
        end else if (row_valid && dx_hit) begin
            pixel_idx <= buf_rdata;
            pixel_on  <= (buf_rdata != TRANSP_IDX);
        end else begin
            pixel_idx <= TRANSP_IDX;
            pixel_on  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// tb/tb_sprite_row_fetcher.sv - scoreboard bench for sprite_row_fetcher with a 1-cycle ROM model
module tb_sprite_row_fetcher;
    import sprite_pkg::*;

    localparam int SX = 200;
    localparam int SY = 100;

    typedef struct {
        pix_t idx;
        logic on;
    } pix_exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        line_start;
    logic [9:0]  line_y;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic [9:0]  DrawX;
    addr_t       rom_addr;
    pix_t        rom_data;
    logic        busy;
    pix_t        pixel_idx;
    logic        pixel_on;
`ifdef SPRITE_HFLIP_EN
    logic        flip_h;
`endif

    int tests = 0;
    int fails = 0;

    addr_t    aq[$];
    pix_exp_t pq[$];

    bit m_valid = 0;
    int m_row   = 0;
    bit m_flip  = 0;

    always #5 Clk = ~Clk;

    // ROM model: mem[a] = a[4:0], one cycle of read latency.
    always @(posedge Clk) rom_data <= rom_addr[4:0];

    sprite_row_fetcher dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .line_start (line_start),
        .line_y     (line_y),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .DrawX      (DrawX),
`ifdef SPRITE_HFLIP_EN
        .flip_h     (flip_h),
`endif
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .busy       (busy),
        .pixel_idx  (pixel_idx),
        .pixel_on   (pixel_on)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_pix(input int x, output pix_exp_t e);
        int dx;
        int c;
        int a;
        dx = x - SX;
        if (m_valid && dx >= 0 && dx < 70) begin
            c     = m_flip ? (69 - dx) : dx;
            a     = m_row * 70 + c;
            e.idx = a[4:0];
            e.on  = (e.idx != 5'h00);
        end else begin
            e.idx = 5'h00;
            e.on  = 1'b0;
        end
    endtask

    task automatic check_pix(input int x);
        pix_exp_t e;
        DrawX = 10'(x);
        exp_pix(x, e);
        pq.push_back(e);
        tick();
        e = pq.pop_front();
        chk($sformatf("pix_idx@%0d", x), 32'(pixel_idx), 32'(e.idx));
        chk($sformatf("pix_on@%0d", x), 32'(pixel_on), 32'(e.on));
    endtask

    task automatic run_fetch(input int ly, input bit hit);
        int    busy_cnt;
        addr_t start_addr;
        addr_t exp_a;
        start_addr = rom_addr;
        aq.delete();
        if (hit) begin
            for (int k = 0; k < 70; k++) aq.push_back(addr_t'((ly - SY) * 70 + k));
        end
        line_y     = 10'(ly);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        busy_cnt   = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy !== 1'b1) break;
            busy_cnt++;
            if (hit && i >= 1 && i <= 70) begin
                exp_a = aq.pop_front();
                chk($sformatf("fetch_addr[%0d]", i - 1), 32'(rom_addr), 32'(exp_a));
            end
            if (i >= 2) chk("pix_off_while_busy", 32'(pixel_on), 32'(0));
            tick();
        end
        chk($sformatf("busy_cycles_line%0d", ly), 32'(busy_cnt), hit ? 32'd72 : 32'd1);
        if (!hit) chk("no_rom_activity", 32'(rom_addr), 32'(start_addr));
        m_valid = hit;
        m_row   = ly - SY;
`ifdef SPRITE_HFLIP_EN
        m_flip  = flip_h;
`endif
    endtask

    initial begin
        Reset_n    = 1'b0;
        line_start = 1'b0;
        line_y     = '0;
        sprite_x   = 10'(SX);
        sprite_y   = 10'(SY);
        DrawX      = '0;
`ifdef SPRITE_HFLIP_EN
        flip_h     = 1'b0;
`endif
        #2;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rom_addr", 32'(rom_addr), 32'(0));
        chk("rst_pixel_on", 32'(pixel_on), 32'(0));
        chk("rst_pixel_idx", 32'(pixel_idx), 32'(0));
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        check_pix(SX + 3);

        // Row 5 fetch, then read back.
        DrawX = 10'(SX + 3);
        run_fetch(105, 1'b1);
        check_pix(SX + 3);
        chk("row5_idx_3", 32'(pixel_idx), 32'h01);
        check_pix(SX + 10);

        // Restart mid-fetch at col 20 with row 6.
        DrawX      = 10'(SX + 3);
        line_y     = 10'd105;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (21) tick();
        chk("abort_point_addr", 32'(rom_addr), 32'd370);
        run_fetch(106, 1'b1);
        check_pix(SX + 3);
        check_pix(SX + 40);

        // Lines just outside the sprite.
        run_fetch(99, 1'b0);
        check_pix(SX);
        check_pix(SX + 3);
        run_fetch(170, 1'b0);
        check_pix(SX + 3);
        check_pix(SX + 69);

        // Row 0: edges and transparency.
        run_fetch(100, 1'b1);
        check_pix(SX - 1);
        check_pix(SX + 70);
        check_pix(SX);
        check_pix(SX + 1);
        chk("row0_on_1", 32'(pixel_on), 32'(1));
        check_pix(SX + 69);

        // Reset in the middle of a fetch.
        DrawX      = 10'(SX + 3);
        line_y     = 10'd105;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (31) tick();
        chk("mid_fetch_addr", 32'(rom_addr), 32'd380);
        chk("mid_fetch_busy", 32'(busy), 32'(1));
        Reset_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'(0));
        chk("async_rst_rom_addr", 32'(rom_addr), 32'(0));
        chk("async_rst_pixel_on", 32'(pixel_on), 32'(0));
        chk("async_rst_pixel_idx", 32'(pixel_idx), 32'(0));
        tick();
        Reset_n = 1'b1;
        m_valid = 0;
        repeat (3) tick();
        chk("post_rst_busy", 32'(busy), 32'(0));
        chk("post_rst_rom_addr", 32'(rom_addr), 32'(0));
        check_pix(SX + 3);

`ifdef SPRITE_HFLIP_EN
        flip_h = 1'b1;
        run_fetch(100, 1'b1);
        check_pix(SX);
        chk("flip_idx_0", 32'(pixel_idx), 32'h05);
        check_pix(SX + 69);
        check_pix(SX + 5);
        flip_h = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
